// File: rtl/adc_vector_expander.sv
// adc_vector_expander: rebuilds a full 64-channel x 16-bit frame from the
// compacted sample stream. Masked channels take the next FIFO word and
// unmasked channels are zero-filled. The rebuilt frame is offered to the
// consumer with a valid/ack handshake.
module adc_vector_expander #(
    parameter int unsigned DEBUG_BUS_SIZE = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic [63:0]               vector_bits,
    input  logic                      fifo_empty,
    output logic                      fifo_pop,
    input  logic [15:0]               fifo_rd_data,
    output logic [1023:0]             frame_out,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic [6:0]                num_active_chans,
    output logic                      err_timeout,
    output logic [DEBUG_BUS_SIZE-1:0] debug
);

    localparam int unsigned NUM_CHANS = 64;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned FRAME_W   = NUM_CHANS * WORD_W;
    localparam int unsigned IDX_W     = 7;
    localparam int unsigned SLOT_W    = 6;
    localparam int unsigned STALL_W   = 16;

    // A limit of zero disables the starvation abort altogether.
    localparam bit                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [STALL_W-1:0] STALL_LIMIT =
        STALL_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        SCAN    = 3'b001,
        POP     = 3'b011,
        CAPTURE = 3'b111,
        DONE    = 3'b110
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_CHANS-1:0]      mask_q, mask_d;
    logic [IDX_W-1:0]          chan_idx_q, chan_idx_d;
    logic [STALL_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic [IDX_W-1:0]          num_q, num_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [DEBUG_BUS_SIZE-1:0] debug_q, debug_d;
    logic [SLOT_W-1:0]         slot_c;

    // Mask bit k lands in slot 63-k, which is the bitwise inverse of k.
    assign slot_c = ~chan_idx_q[SLOT_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            chan_idx_q  <= '0;
            stall_cnt_q <= '0;
            frame_q     <= '0;
            num_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            debug_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            chan_idx_q  <= chan_idx_d;
            stall_cnt_q <= stall_cnt_d;
            frame_q     <= frame_d;
            num_q       <= num_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            debug_q     <= debug_d;
        end
    end

    // Next-state, pop strobe and datapath updates.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        chan_idx_d  = chan_idx_q;
        stall_cnt_d = stall_cnt_q;
        frame_d     = frame_q;
        num_d       = num_q;
        err_d       = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    mask_d     = vector_bits;
                    frame_d    = '0;
                    chan_idx_d = '0;
                    num_d      = '0;
                end
            end
            SCAN: begin
                if (chan_idx_q == IDX_W'(NUM_CHANS)) begin
                    state_d = DONE;
                end else if (mask_q[chan_idx_q[SLOT_W-1:0]]) begin
                    state_d     = POP;
                    stall_cnt_d = '0;
                end else begin
                    chan_idx_d = chan_idx_q + IDX_W'(1);
                end
            end
            POP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = CAPTURE;
                end else if (TIMEOUT_EN && (stall_cnt_q == STALL_LIMIT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            CAPTURE: begin
                frame_d[slot_c*WORD_W +: WORD_W] = fifo_rd_data;
                chan_idx_d = chan_idx_q + IDX_W'(1);
                num_d      = num_q + IDX_W'(1);
                state_d    = SCAN;
            end
            DONE: begin
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered flags follow the next state so they line up with the state register.
    always_comb begin
        valid_d = (state_d == DONE);
        debug_d = DEBUG_BUS_SIZE'({start, state_d});
    end

    assign frame_out        = frame_q;
    assign frame_valid      = valid_q;
    assign num_active_chans = num_q;
    assign err_timeout      = err_q;
    assign debug            = debug_q;

endmodule

// File: tb/tb_adc_vector_expander.sv
// tb_adc_vector_expander: directed and randomized frames against a slot-level
// reference model, plus starvation abort and mid-frame reset scenarios.
module tb_adc_vector_expander;

    logic          clk = 1'b0;
    logic          rstb;
    logic          start;
    logic [63:0]   vector_bits;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [15:0]   fifo_rd_data = 16'h0;
    logic [1023:0] frame_out;
    logic          frame_valid;
    logic          frame_ack;
    logic [6:0]    num_active_chans;
    logic          err_timeout;
    logic [3:0]    debug;

    // Second instance with a short timeout and a permanently empty FIFO.
    logic          start_b;
    logic          fifo_pop_b;
    logic [1023:0] frame_out_b;
    logic          frame_valid_b;
    logic [6:0]    num_b;
    logic          err_b;
    logic [3:0]    debug_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0]   fifo_mem [0:2047];
    int            wr_ptr    = 0;
    int            rd_ptr    = 0;
    int            pop_count = 0;
    int            bad_pops  = 0;
    logic          hold_empty;
    logic [15:0]   wbuf [0:63];
    logic [1023:0] cur_exp;
    int            cur_n;

    adc_vector_expander #(.DEBUG_BUS_SIZE(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rstb(rstb), .start(start), .vector_bits(vector_bits),
        .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_rd_data(fifo_rd_data),
        .frame_out(frame_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .num_active_chans(num_active_chans), .err_timeout(err_timeout), .debug(debug)
    );

    adc_vector_expander #(.DEBUG_BUS_SIZE(4), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rstb(rstb), .start(start_b), .vector_bits(64'h1),
        .fifo_empty(1'b1), .fifo_pop(fifo_pop_b), .fifo_rd_data(16'h0),
        .frame_out(frame_out_b), .frame_valid(frame_valid_b), .frame_ack(1'b0),
        .num_active_chans(num_b), .err_timeout(err_b), .debug(debug_b)
    );

    always #5 clk = ~clk;

    assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);

    // FIFO model: head word appears on fifo_rd_data the cycle after a pop.
    always @(posedge clk) begin
        if (fifo_pop) begin
            pop_count <= pop_count + 1;
            if (fifo_empty) begin
                bad_pops <= bad_pops + 1;
            end else begin
                fifo_rd_data <= fifo_mem[rd_ptr[10:0]];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk channels in ascending order, consuming words into mirrored slots.
    function automatic logic [1023:0] model_frame(input logic [63:0] mask);
        logic [15:0]   slots [64];
        logic [1023:0] f;
        int            j = 0;
        for (int s = 0; s < 64; s++) slots[s] = 16'h0;
        for (int k = 0; k < 64; k++) begin
            if (mask[k]) begin
                slots[63 - k] = wbuf[j];
                j++;
            end
        end
        f = '0;
        for (int s = 0; s < 64; s++) f[s*16 +: 16] = slots[s];
        return f;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " frame"}, frame_out, '0);
        chk_i({tag, " active"}, int'(num_active_chans), 0);
        chk_i({tag, " valid"}, int'(frame_valid), 0);
        chk_i({tag, " err"}, int'(err_timeout), 0);
        chk_i({tag, " pop"}, int'(fifo_pop), 0);
        chk_i({tag, " debug"}, int'(debug), 0);
        chk({tag, " frame_b"}, frame_out_b, '0);
        chk_i({tag, " active_b"}, int'(num_b), 0);
        chk_i({tag, " debug_b"}, int'(debug_b), 0);
    endtask

    // Loads words, starts a frame at cycle 0 and measures the cycle frame_valid rises.
    task automatic run_frame(input string tag, input logic [63:0] mask, input int n_stall);
        int n, first_k, lat, p0, b0, release_c;
        n       = $countones(mask);
        cur_exp = model_frame(mask);
        cur_n   = n;
        first_k = 0;
        for (int k = 63; k >= 0; k--) if (mask[k]) first_k = k;
        release_c = 2 + first_k + n_stall;
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[10:0]] = wbuf[i];
            wr_ptr++;
        end
        hold_empty  = (n_stall > 0);
        p0          = pop_count;
        b0          = bad_pops;
        vector_bits = mask;
        start       = 1'b1;
        lat         = -1;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (c == 1) begin
                start       = 1'b0;
                vector_bits = {$urandom, $urandom};
            end
            if (c == release_c) hold_empty = 1'b0;
            if (frame_valid) begin
                lat = c;
                break;
            end
        end
        hold_empty = 1'b0;
        chk_i({tag, " latency"}, lat, 66 + 2 * n + n_stall);
        chk({tag, " frame"}, frame_out, cur_exp);
        chk_i({tag, " active"}, int'(num_active_chans), n);
        chk_i({tag, " pops"}, pop_count - p0, n);
        chk_i({tag, " empty pops"}, bad_pops - b0, 0);
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk_i({tag, " valid after ack"}, int'(frame_valid), 0);
    endtask

    task automatic timeout_run(input string tag);
        int pulses, at, vb, pb;
        pulses  = 0;
        at      = -1;
        vb      = 0;
        pb      = 0;
        start_b = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1) start_b = 1'b0;
            if (err_b) begin
                pulses++;
                if (at < 0) at = c;
            end
            if (frame_valid_b) vb++;
            if (fifo_pop_b) pb++;
        end
        chk_i({tag, " pulses"}, pulses, 1);
        chk_i({tag, " pulse cycle"}, at, 10);
        chk_i({tag, " valid cycles"}, vb, 0);
        chk_i({tag, " pops"}, pb, 0);
        chk_i({tag, " idle"}, int'(debug_b[2:0]), 0);
    endtask

    initial begin
        logic [63:0] m;
        int          st;

        rstb        = 1'b0;
        start       = 1'b0;
        start_b     = 1'b0;
        vector_bits = '0;
        frame_ack   = 1'b0;
        hold_empty  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rstb = 1'b1;
        step();
        step();

        run_frame("zero mask", 64'h0, 0);
        ack_frame("zero mask");

        for (int k = 0; k < 64; k++) wbuf[k] = 16'(k);
        run_frame("full mask", 64'hFFFF_FFFF_FFFF_FFFF, 0);
        ack_frame("full mask");

        wbuf[0] = 16'hA5A5;
        wbuf[1] = 16'h5A5A;
        run_frame("end bits", 64'h8000_0000_0000_0001, 0);
        ack_frame("end bits");

        wbuf[0] = 16'h1234;
        run_frame("stall", 64'h1, 10);
        ack_frame("stall");

        for (int r = 0; r < 6; r++) begin
            m = {$urandom, $urandom};
            if (r[0]) m = m & {$urandom, $urandom};
            st = (m == 64'h0) ? 0 : int'($urandom_range(0, 5));
            for (int k = 0; k < 64; k++) wbuf[k] = 16'($urandom);
            run_frame($sformatf("random%0d", r), m, st);
            ack_frame($sformatf("random%0d", r));
        end

        for (int k = 0; k < 64; k++) wbuf[k] = 16'($urandom);
        run_frame("hold", {$urandom, $urandom}, 0);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold frame", frame_out, cur_exp);
            chk_i("hold valid", int'(frame_valid), 1);
            chk_i("hold active", int'(num_active_chans), cur_n);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk_i("ack+start valid", int'(frame_valid), 0);
        chk_i("ack+start idle", int'(debug[2:0]), 0);
        for (int k = 0; k < 64; k++) wbuf[k] = 16'($urandom);
        run_frame("restart", {$urandom, $urandom} & {$urandom, $urandom}, 0);
        ack_frame("restart");

        timeout_run("timeout");
        timeout_run("timeout again");

        wbuf[0] = 16'hBEEF;
        fifo_mem[wr_ptr[10:0]] = wbuf[0];
        wr_ptr++;
        vector_bits = 64'h1;
        start       = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) start = 1'b0;
        end
        chk("midscan partial", frame_out, model_frame(64'h1));
        rstb = 1'b0;
        #1;
        chk_reset("midscan reset");
        step();
        rstb = 1'b1;
        step();
        for (int k = 0; k < 64; k++) wbuf[k] = 16'($urandom);
        run_frame("after reset", {$urandom, $urandom}, 0);
        ack_frame("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
